serial_pattern_tx: RTL
======================

Name: serial_pattern_tx

Overview:
Serial bit-pattern transmitter that drives single-bit sequence detectors such as the 1101 FSM detector.
- Accepts a parallel pattern word and a bit length through a valid/ready load handshake.
- Shifts the pattern out one bit per clock, MSB of the programmed length first.
- Used as the stimulus/transmit end feeding the detector's data_in, and as an on-chip pattern source.

Parameters:
MAX_LEN, 32, maximum pattern length in bits (width of load_data)
LEN_W, 6, width of load_len; must satisfy 2**LEN_W > MAX_LEN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  pattern offered this cycle
load_ready  output  1  block can accept a pattern this cycle
load_data  input  MAX_LEN  pattern bits; bit [len-1] is sent first, bit [0] last
load_len  input  LEN_W  number of bits to send (0..2**LEN_W-1)
data_out  output  1  serial bit; drive to the detector's data_in
data_out_valid  output  1  data_out carries a pattern bit this cycle
busy  output  1  shift in progress
done  output  1  one-cycle pulse on the final cycle of a pattern

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - data_out=0, data_out_valid=0, busy=0, done=0, load_ready=1 (after release).
  - Shift register and bit counter are cleared.
  - Reset mid-shift aborts the pattern immediately; no done pulse is produced.
- States:
  - IDLE: load_ready=1, data_out=0, data_out_valid=0.
  - SHIFT: busy=1, data_out_valid=1, one bit per cycle.
- Handshake:
  - Transfer occurs on a rising edge with load_valid=1 and load_ready=1.
  - load_data and load_len are sampled only on that edge.
- Length rules:
  - Effective length L = min(load_len, MAX_LEN).
  - load_len=0: accepted, no bits sent. State stays IDLE, done=1 for the single cycle after acceptance, data_out_valid stays 0.
- Latency:
  - Accept on edge T → bit [L-1] is registered on data_out from edge T through edge T+1.
  - Bit [L-1-k] is presented during cycle T+k, for k = 0..L-1.
  - data_out and data_out_valid are registered outputs (no combinational path from load_*).
- Last bit:
  - During the cycle presenting bit [0], done=1 and load_ready=1.
  - If a new load is accepted on that edge, its first bit follows with no gap, and busy and data_out_valid stay 1.
  - Otherwise the block returns to IDLE: data_out=0, data_out_valid=0.
- load_ready=0 during every other SHIFT cycle. load_valid is ignored then, and the offered data must be held by the source.
- Counter: LEN_W-bit down-counter loaded with L-1; no wrap past 0, and the transition out of SHIFT occurs at 0.
- Pattern bits above index L-1 are ignored.

Optional Feature:
SERIAL_PATTERN_TX_REPEAT_EN
- Defined:
  - Adds input port repeat_en (1 bit).
  - If repeat_en=1 on the edge that ends bit [0] and no new load is accepted on that edge, the stored pattern restarts at bit [L-1] with no gap. done still pulses on each pass.
  - A new load accepted on that edge takes priority over repeat.
  - repeat_en is sampled only at pattern end.
  - repeat with L=0 behaves as single-shot.
- Not defined: no repeat_en port; patterns are single-shot only.

Test Plan:
- Basic pattern: load 32'b1101, len 4 at edge T.
  - data_out = 1,1,0,1 in cycles T..T+3 with data_out_valid=1.
  - done=1 only in cycle T+3.
  - A connected fsm_sequence_detector_1101 reports exactly 1 detection.
- Back-to-back: load 1101/len4, then 1101/len4 accepted in the done cycle.
  - 8 contiguous valid bits 11011101, two done pulses 4 cycles apart, detector count 2.
- Boundary lengths:
  - len 0 → done pulse 1 cycle after acceptance, data_out_valid never 1.
  - len 40 with MAX_LEN=32 → exactly 32 valid bits, starting from load_data[31].
- Backpressure: hold load_valid=1 with a second pattern during SHIFT.
  - load_ready=0 until the last bit; second pattern accepted only in that cycle, no bits lost or duplicated.
- Reset mid-operation: assert rst_n=0 while bit 2 of 1111101/len7 is shown.
  - data_out=0, data_out_valid=0, busy=0 immediately; no done pulse.
  - load_ready=1 after release; new 1101 load sends correctly.
- Repeat (SERIAL_PATTERN_TX_REPEAT_EN): load 1101/len4 with repeat_en=1 for 3 passes, then 0.
  - 12 contiguous bits 110111011101, 3 done pulses, then IDLE.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded word out one bit per clock, bit [len-1] first.
// Build option SERIAL_PATTERN_TX_REPEAT_EN adds repeat_en to replay the stored pattern without a gap.
module serial_pattern_tx #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    input  logic               repeat_en,
`endif
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    output logic               data_out,
    output logic               data_out_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               dout_q, dout_d;
    logic               dvld_q, dvld_d;
    logic               zdone_q, zdone_d;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   plen_q, plen_d;
`endif

    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   load_sh;
    logic [MAX_LEN-1:0] load_aligned;
    logic               accept;

    // Left-align the pattern so bit [L-1] sits at the MSB; bits above L-1 fall off the top.
    assign eff_len      = (load_len > MAX_LEN_L) ? MAX_LEN_L : load_len;
    assign load_sh      = MAX_LEN_L - eff_len;
    assign load_aligned = load_data << load_sh;

    assign load_ready     = (state_q == IDLE) || (cnt_q == '0);
    assign accept         = load_valid && load_ready;
    assign busy           = (state_q == SHIFT);
    assign done           = ((state_q == SHIFT) && (cnt_q == '0)) || zdone_q;
    assign data_out       = dout_q;
    assign data_out_valid = dvld_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = 1'b0;
        dvld_d  = 1'b0;
        zdone_d = 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        pat_d   = pat_q;
        plen_d  = plen_q;
`endif
        if (accept) begin
            if (eff_len == '0) begin
                // Zero-length load: nothing to send, just acknowledge with done next cycle.
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
                zdone_d = 1'b1;
            end else begin
                state_d = SHIFT;
                dout_d  = load_aligned[MAX_LEN-1];
                dvld_d  = 1'b1;
                sr_d    = load_aligned << 1;
                cnt_d   = eff_len - LEN_W'(1);
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                pat_d   = load_aligned;
                plen_d  = eff_len;
`endif
            end
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                state_d = SHIFT;
                dout_d  = sr_q[MAX_LEN-1];
                dvld_d  = 1'b1;
                sr_d    = sr_q << 1;
                cnt_d   = cnt_q - LEN_W'(1);
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            end else if (repeat_en && (plen_q != '0)) begin
                state_d = SHIFT;
                dout_d  = pat_q[MAX_LEN-1];
                dvld_d  = 1'b1;
                sr_d    = pat_q << 1;
                cnt_d   = plen_q - LEN_W'(1);
`endif
            end else begin
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            dvld_q  <= 1'b0;
            zdone_q <= 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            pat_q   <= '0;
            plen_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            zdone_q <= zdone_d;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            pat_q   <= pat_d;
            plen_q  <= plen_d;
`endif
        end
    end

endmodule
